// File: rtl/covariance_unit_pkg.sv
// Sizing defaults and FSM encoding shared by the covariance unit.
package covariance_unit_pkg;

    localparam int N_SAMPLES = 128;
    localparam int LOG2_N    = $clog2(N_SAMPLES);
    localparam int DATA_W    = 16;
    localparam int ACC_W     = 2 * DATA_W + LOG2_N;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACC   = 3'd1,
        S_DRAIN = 3'd2,
        S_SCALE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/covariance_unit_mac.sv
// Signed multiply, product register and accumulator for one covariance term.
module cov_mac
    import covariance_unit_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = ACC_W
) (
    input  logic                 clk_i,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic signed [DW-1:0] a_i,
    input  logic signed [DW-1:0] b_i,
    output logic signed [AW-1:0] acc_o
);

    localparam int PW = 2 * DW;

    logic signed [PW-1:0] prod_q, prod_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic                 pv_q, pv_d;

    // Product lands one cycle after en_i, accumulated the cycle after.
    always_comb begin
        prod_d = prod_q;
        pv_d   = en_i;
        acc_d  = acc_q;
        if (en_i) begin
            prod_d = PW'(a_i) * PW'(b_i);
        end
        if (pv_q) begin
            acc_d = acc_q + AW'(prod_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            prod_q <= '0;
            pv_q   <= 1'b0;
            acc_q  <= '0;
        end else begin
            prod_q <= prod_d;
            pv_q   <= pv_d;
            acc_q  <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/covariance_unit.sv
// Frame-based covariance of two centered channels: E[x1^2], E[x1*x2], E[x2^2].
module covariance_unit #(
    parameter int N_SAMPLES = covariance_unit_pkg::N_SAMPLES,
    parameter int DATA_W    = covariance_unit_pkg::DATA_W
) (
    input  logic                     CLK_cov,
    input  logic                     GO_cov,
    input  logic                     En_cov,
    input  logic signed [DATA_W-1:0] x1,
    input  logic signed [DATA_W-1:0] x2,
    output logic                     COV_busy,
    output logic                     COV_done,
    output logic signed [2*DATA_W-1:0] c11,
    output logic signed [2*DATA_W-1:0] c12,
    output logic signed [2*DATA_W-1:0] c22
);
    import covariance_unit_pkg::*;

    localparam int LG = $clog2(N_SAMPLES);
    localparam int AW = 2 * DATA_W + LG;
    localparam int PW = 2 * DATA_W;

    state_e state_q, state_d;

    logic [LG-1:0]            cnt_q, cnt_d;
    logic                     wrap_q, wrap_d;
    logic                     v_q, v_d;
    logic signed [DATA_W-1:0] x1_q, x1_d, x2_q, x2_d;
    logic signed [PW-1:0]     c11_q, c11_d, c12_q, c12_d, c22_q, c22_d;
    logic signed [AW-1:0]     a11, a12, a22;
    logic                     accept, clr;

    assign clr = !GO_cov;

    // Once the last pair is taken, ACC lingers a cycle but accepts nothing.
    assign accept = En_cov &&
        (state_q == S_IDLE || (state_q == S_ACC && !wrap_q));

    always_ff @(posedge CLK_cov) begin
        if (!GO_cov) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (En_cov) state_d = S_ACC;
            S_ACC:   if (wrap_q) state_d = S_DRAIN;
            S_DRAIN: state_d = S_SCALE;
            S_SCALE: state_d = S_DONE;
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        COV_busy = 1'b0;
        COV_done = 1'b0;
        unique case (state_q)
            S_ACC, S_DRAIN, S_SCALE: COV_busy = 1'b1;
            S_DONE:                  COV_done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = wrap_q;
        v_d    = accept;
        x1_d   = x1_q;
        x2_d   = x2_q;
        c11_d  = c11_q;
        c12_d  = c12_q;
        c22_d  = c22_q;
        if (accept) begin
            cnt_d = cnt_q + LG'(1);
            x1_d  = x1;
            x2_d  = x2;
            if (cnt_q == '1) wrap_d = 1'b1;
        end
        if (state_q == S_SCALE) begin
            c11_d = PW'(a11 >>> LG);
            c12_d = PW'(a12 >>> LG);
            c22_d = PW'(a22 >>> LG);
        end
    end

    always_ff @(posedge CLK_cov) begin
        if (!GO_cov) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            v_q    <= 1'b0;
            x1_q   <= '0;
            x2_q   <= '0;
            c11_q  <= '0;
            c12_q  <= '0;
            c22_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            v_q    <= v_d;
            x1_q   <= x1_d;
            x2_q   <= x2_d;
            c11_q  <= c11_d;
            c12_q  <= c12_d;
            c22_q  <= c22_d;
        end
    end

    cov_mac #(.DW(DATA_W), .AW(AW)) u_m11 (
        .clk_i(CLK_cov), .clr_i(clr), .en_i(v_q),
        .a_i(x1_q), .b_i(x1_q), .acc_o(a11)
    );

    cov_mac #(.DW(DATA_W), .AW(AW)) u_m12 (
        .clk_i(CLK_cov), .clr_i(clr), .en_i(v_q),
        .a_i(x1_q), .b_i(x2_q), .acc_o(a12)
    );

    cov_mac #(.DW(DATA_W), .AW(AW)) u_m22 (
        .clk_i(CLK_cov), .clr_i(clr), .en_i(v_q),
        .a_i(x2_q), .b_i(x2_q), .acc_o(a22)
    );

    assign c11 = c11_q;
    assign c12 = c12_q;
    assign c22 = c22_q;

endmodule

// File: tb/tb_covariance_unit.sv
// Scoreboard bench for covariance_unit: frames, stalls, resets, DONE hold.
module tb_covariance_unit;

    localparam int DW = 16;
    localparam int NS = 128;
    localparam int LG = 7;

    logic                   clk = 1'b0;
    logic                   go;
    logic                   en;
    logic signed [DW-1:0]   x1, x2;
    logic                   busy, done;
    logic signed [2*DW-1:0] c11, c12, c22;

    typedef struct {
        longint c11;
        longint c12;
        longint c22;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_e;
    int   n_pass = 0;
    int   n_tot  = 0;

    covariance_unit #(.N_SAMPLES(NS), .DATA_W(DW)) dut (
        .CLK_cov (clk),
        .GO_cov  (go),
        .En_cov  (en),
        .x1      (x1),
        .x2      (x2),
        .COV_busy(busy),
        .COV_done(done),
        .c11     (c11),
        .c12     (c12),
        .c22     (c22)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got,
                       input longint exp);
        n_tot++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        go = 1'b0;
        en = 1'b1;
        x1 = DW'($urandom);
        x2 = DW'($urandom);
        repeat (2) @(negedge clk);
        go = 1'b1;
        en = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_frame(input string tag, input int a, input int b,
                             input bit rnd, input bit tgl,
                             input int exp_busy);
        longint s11 = 0, s12 = 0, s22 = 0;
        int     av, bv, busy_n, lat;
        exp_t   e;
        busy_n = 0;
        for (int i = 0; i < NS; i++) begin
            av = a;
            bv = b;
            if (rnd) begin
                av = int'($urandom_range(65535)) - 32768;
                bv = int'($urandom_range(65535)) - 32768;
            end
            @(negedge clk);
            if (busy) busy_n++;
            en = 1'b1;
            x1 = av[DW-1:0];
            x2 = bv[DW-1:0];
            s11 += longint'(av) * av;
            s12 += longint'(av) * bv;
            s22 += longint'(bv) * bv;
            if (tgl && i < NS - 1) begin
                @(negedge clk);
                if (busy) busy_n++;
                en = 1'b0;
                x1 = DW'($urandom);
                x2 = DW'($urandom);
            end
        end
        e.c11 = s11 >>> LG;
        e.c12 = s12 >>> LG;
        e.c22 = s22 >>> LG;
        exp_q.push_back(e);
        lat = 0;
        do begin
            @(negedge clk);
            en = 1'b0;
            if (busy) busy_n++;
            lat++;
        end while (!done && lat < 20);
        chk({tag, "_lat"}, lat, 4);
        chk({tag, "_busy_cycles"}, busy_n, exp_busy);
        chk({tag, "_busy_end"}, busy, 0);
        e = exp_q.pop_front();
        last_e = e;
        chk({tag, "_c11"}, c11, e.c11);
        chk({tag, "_c12"}, c12, e.c12);
        chk({tag, "_c22"}, c22, e.c22);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        go = 1'b0;
        en = 1'b0;
        x1 = '0;
        x2 = '0;

        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_c11", c11, 0);
        chk("rst_c12", c12, 0);
        chk("rst_c22", c22, 0);

        run_frame("const", 100, 100, 1'b0, 1'b0, NS + 2);
        chk("const_exact", c11, 10000);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            en = 1'b1;
            x1 = DW'($urandom);
            x2 = DW'($urandom);
            @(negedge clk);
            en = 1'b0;
        end
        chk("hold_done", done, 1);
        chk("hold_busy", busy, 0);
        chk("hold_c11", c11, last_e.c11);
        chk("hold_c12", c12, last_e.c12);
        chk("hold_c22", c22, last_e.c22);

        do_reset();
        run_frame("anti", 100, -100, 1'b0, 1'b0, NS + 2);
        chk("anti_exact", c12, -10000);

        do_reset();
        run_frame("stall", 100, 100, 1'b0, 1'b1, 2 * NS - 1 + 2);

        do_reset();
        run_frame("extreme", -32768, -32768, 1'b0, 1'b0, NS + 2);
        chk("extreme_exact", c12, 1073741824);

        do_reset();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            en = 1'b1;
            x1 = DW'($urandom);
            x2 = DW'($urandom);
        end
        do_reset();
        chk("midrst_busy", busy, 0);
        chk("midrst_c11", c11, 0);
        run_frame("midrst", 3, -5, 1'b0, 1'b0, NS + 2);
        chk("midrst_exact", c12, -15);

        do_reset();
        run_frame("rand0", 0, 0, 1'b1, 1'b0, NS + 2);
        do_reset();
        run_frame("rand1", 0, 0, 1'b1, 1'b1, 2 * NS - 1 + 2);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
